// File: rtl/lsu.sv
// Load/store unit: turns one core load/store request into one Wishbone
// transfer to the data SRAM and returns a single-cycle response strobe.
// Optional build macro: LSU_MISALIGN_TRAP_EN rejects misaligned halfword
// and word accesses without touching the bus. When it is undefined,
// misalignment is ignored (halfwords use adr[1] only, words no low bits).
//
// state  | meaning
// IDLE   | ready for a request
// BUS    | Wishbone cycle in flight, waiting for ack or timeout
// RSP    | one-cycle response strobe
module lsu #(
  parameter int TIMEOUT = 15
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_adr,
  input  logic [31:0] i_req_dat,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_dat,
  output logic        o_rsp_err,
  output logic        o_rsp_misalign,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RSP  = 2'd2;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [7:0]  cnt;
  logic        we;
  logic [2:0]  funct3;
  logic [1:0]  off;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        rsp_mis;

  logic        accept;
  logic        illegal;
  logic        mis_trap;
  logic [3:0]  sel_next;
  logic [31:0] dat_next;
  logic [1:0]  off_next;
  logic [31:0] shifted;
  logic [31:0] load_val;

  assign o_req_ready = (state == S_IDLE) && i_rst_n;
  assign accept      = i_req_valid && o_req_ready;
  assign o_wb_cyc    = (state == S_BUS);
  assign o_rsp_valid = (state == S_RSP);
  assign o_rsp_dat      = o_rsp_valid ? rsp_dat : 32'h0;
  assign o_rsp_err      = o_rsp_valid & rsp_err;
  assign o_rsp_misalign = o_rsp_valid & rsp_mis;

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis_trap = ((i_req_funct3[1:0] == 2'b01) && i_req_adr[0]) ||
                    ((i_req_funct3[1:0] == 2'b10) && (i_req_adr[1:0] != 2'b00));
`else
  assign mis_trap = 1'b0;
`endif

  // Request decode: legality, byte lanes, replicated store data, lane offset
  always_comb begin
    if (i_req_we)
      illegal = i_req_funct3[2] || (i_req_funct3[1:0] == 2'b11);
    else
      illegal = (i_req_funct3[1:0] == 2'b11) || (i_req_funct3[2] && i_req_funct3[1]);
    sel_next = 4'b1111;
    dat_next = i_req_dat;
    off_next = 2'b00;
    case (i_req_funct3[1:0])
      2'b00: begin
        sel_next = 4'b0001 << i_req_adr[1:0];
        dat_next = {4{i_req_dat[7:0]}};
        off_next = i_req_adr[1:0];
      end
      2'b01: begin
        sel_next = 4'b0011 << {i_req_adr[1], 1'b0};
        dat_next = {2{i_req_dat[15:0]}};
        off_next = {i_req_adr[1], 1'b0};
      end
      default: begin
        sel_next = 4'b1111;
        dat_next = i_req_dat;
        off_next = 2'b00;
      end
    endcase
  end

  // Load extraction: align the addressed lane to bit 0, then extend
  always_comb begin
    shifted = i_wb_rdt >> {off, 3'b000};
    case (funct3)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_val = {24'h0, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_val = {16'h0, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  // Sequencer: accept, run the bus cycle with timeout, emit the response
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      cnt      <= 8'h0;
      we       <= 1'b0;
      funct3   <= 3'b000;
      off      <= 2'b00;
      rsp_dat  <= 32'h0;
      rsp_err  <= 1'b0;
      rsp_mis  <= 1'b0;
      o_wb_adr <= 32'h0;
      o_wb_dat <= 32'h0;
      o_wb_sel <= 4'h0;
      o_wb_we  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            cnt      <= 8'h0;
            we       <= i_req_we;
            funct3   <= i_req_funct3;
            off      <= off_next;
            o_wb_adr <= {i_req_adr[31:2], 2'b00};
            o_wb_dat <= dat_next;
            o_wb_sel <= sel_next;
            o_wb_we  <= i_req_we;
            rsp_dat  <= 32'h0;
            if (illegal) begin
              state   <= S_RSP;
              rsp_err <= 1'b1;
              rsp_mis <= 1'b0;
            end else if (mis_trap) begin
              state   <= S_RSP;
              rsp_err <= 1'b0;
              rsp_mis <= 1'b1;
            end else begin
              state   <= S_BUS;
              rsp_err <= 1'b0;
              rsp_mis <= 1'b0;
            end
          end
        end
        S_BUS: begin
          if (i_wb_ack) begin
            state   <= S_RSP;
            rsp_dat <= we ? 32'h0 : load_val;
            rsp_err <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state   <= S_RSP;
            rsp_dat <= 32'h0;
            rsp_err <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_RSP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
